// File: rtl/fl_ifnum_merge_pkg.sv
// Shared types and elaboration-time helpers for the FrameLink N-to-1 merger.
package fl_ifnum_merge_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } merge_state_e;

    function automatic int ifnum_width(input int if_count);
        return (if_count > 1) ? $clog2(if_count) : 1;
    endfunction

    function automatic int hdr_word(input int offset, input int data_width);
        return offset / data_width;
    endfunction

    function automatic int hdr_bit(input int offset, input int data_width);
        return offset % data_width;
    endfunction

    function automatic int rem_width(input int data_width);
        return (data_width >= 16) ? $clog2(data_width / 8) : 1;
    endfunction

    function automatic bit cfg_ok(input int data_width, input int if_count, input int offset);
        return (data_width >= 8) && (data_width % 8 == 0) &&
               (if_count >= 2) && ((if_count & (if_count - 1)) == 0) &&
               (offset >= 0) &&
               (hdr_bit(offset, data_width) + ifnum_width(if_count) <= data_width);
    endfunction

endpackage

// File: rtl/fl_ifnum_merge_arb.sv
// Round-robin request/grant: first requester at or after the pointer wins.
module fl_ifnum_merge_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    input  logic [IW-1:0] adv_idx_i,
    output logic          gnt_vld_o,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;

    // Scan from the farthest candidate down so the closest one to ptr_q wins.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr_q + IW'(k);
            if (req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = idx;
            end
        end
        gnt_oh_o = gnt_vld_o ? (N'(1) << gnt_idx_o) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = adv_idx_i + IW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fl_ifnum_merge.sv
// FrameLink N-to-1 frame-atomic round-robin merger with one-word output register.
// FL_IFNUM_MERGE_MARK_EN: write the source input number into the header field.
//   state     | meaning
//   ST_IDLE   | between frames; arbitrate among inputs presenting SOF
//   ST_LOCKED | mid-frame; only the granted input is served until its EOF
module fl_ifnum_merge
    import fl_ifnum_merge_pkg::*;
#(
    parameter int  DATA_WIDTH   = 16,
    parameter int  IF_COUNT     = 4,
    parameter int  IFNUM_OFFSET = 167,
    localparam int REM_W        = rem_width(DATA_WIDTH)
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic [IF_COUNT*DATA_WIDTH-1:0] RX_DATA,
    input  logic [IF_COUNT*REM_W-1:0]      RX_REM,
    input  logic [IF_COUNT-1:0]            RX_SOF_N,
    input  logic [IF_COUNT-1:0]            RX_EOF_N,
    input  logic [IF_COUNT-1:0]            RX_SOP_N,
    input  logic [IF_COUNT-1:0]            RX_EOP_N,
    input  logic [IF_COUNT-1:0]            RX_SRC_RDY_N,
    output logic [IF_COUNT-1:0]            RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]          TX_DATA,
    output logic [REM_W-1:0]               TX_REM,
    output logic                           TX_SOF_N,
    output logic                           TX_EOF_N,
    output logic                           TX_SOP_N,
    output logic                           TX_EOP_N,
    output logic                           TX_SRC_RDY_N,
    input  logic                           TX_DST_RDY_N
);

    localparam int IW = ifnum_width(IF_COUNT);

    if (!cfg_ok(DATA_WIDTH, IF_COUNT, IFNUM_OFFSET)) begin : g_cfg_err
        $error("fl_ifnum_merge: bad generics (width, port count or field position)");
    end

    logic [DATA_WIDTH-1:0] rx_data_a [IF_COUNT];
    logic [REM_W-1:0]      rx_rem_a  [IF_COUNT];

    for (genvar g = 0; g < IF_COUNT; g++) begin : g_unpack
        assign rx_data_a[g] = RX_DATA[g*DATA_WIDTH +: DATA_WIDTH];
        assign rx_rem_a[g]  = RX_REM[g*REM_W +: REM_W];
    end

    merge_state_e          state_q, state_d;
    logic [IW-1:0]         lock_idx_q, lock_idx_d;

    logic                  tx_vld_q, tx_vld_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [REM_W-1:0]      tx_rem_q, tx_rem_d;
    logic [3:0]            tx_dlm_q, tx_dlm_d;

    logic                  arb_vld;
    logic [IF_COUNT-1:0]   arb_oh;
    logic [IW-1:0]         arb_idx;

    logic                  sel_vld;
    logic [IF_COUNT-1:0]   sel_oh;
    logic [IW-1:0]         sel_idx;

    logic                  can_load;
    logic                  accept;
    logic                  adv;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [DATA_WIDTH-1:0] rx_data_mod;
    logic [REM_W-1:0]      rx_rem;
    logic                  rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n;

    fl_ifnum_merge_arb #(
        .N  (IF_COUNT),
        .IW (IW)
    ) u_arb (
        .clk_i     (CLK),
        .rst_n_i   (RESET_N),
        .req_i     (~RX_SRC_RDY_N & ~RX_SOF_N),
        .adv_i     (adv),
        .adv_idx_i (sel_idx),
        .gnt_vld_o (arb_vld),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        sel_vld = arb_vld;
        sel_oh  = arb_oh;
        sel_idx = arb_idx;
        if (state_q == ST_LOCKED) begin
            sel_vld = 1'b1;
            sel_idx = lock_idx_q;
            sel_oh  = IF_COUNT'(1) << lock_idx_q;
        end
    end

    assign rx_data  = rx_data_a[sel_idx];
    assign rx_rem   = rx_rem_a[sel_idx];
    assign rx_sof_n = RX_SOF_N[sel_idx];
    assign rx_eof_n = RX_EOF_N[sel_idx];
    assign rx_sop_n = RX_SOP_N[sel_idx];
    assign rx_eop_n = RX_EOP_N[sel_idx];

    // Output register can take a word if it is empty or its word leaves this cycle.
    assign can_load     = !tx_vld_q || !TX_DST_RDY_N;
    assign accept       = RESET_N && sel_vld && can_load && !RX_SRC_RDY_N[sel_idx];
    assign adv          = accept && !rx_eof_n;
    assign RX_DST_RDY_N = (RESET_N && sel_vld && can_load) ? ~sel_oh : '1;

`ifdef FL_IFNUM_MERGE_MARK_EN
    localparam int HW = hdr_word(IFNUM_OFFSET, DATA_WIDTH);
    localparam int HB = hdr_bit(IFNUM_OFFSET, DATA_WIDTH);
    localparam int CW = $clog2(HW + 2);

    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] widx;
    logic          in_hdr_q, in_hdr_d;
    logic          hdr_now;
    logic          mark;

    // Counter saturates at HW+1 so very long headers are marked only once.
    always_comb begin
        widx        = rx_sof_n ? wcnt_q : '0;
        hdr_now     = !rx_sof_n || in_hdr_q;
        mark        = hdr_now && (widx == CW'(HW));
        rx_data_mod = rx_data;
        if (mark) rx_data_mod[HB +: IW] = sel_idx;
        wcnt_d   = wcnt_q;
        in_hdr_d = in_hdr_q;
        if (accept) begin
            in_hdr_d = hdr_now && rx_eop_n;
            wcnt_d   = widx;
            if (hdr_now && rx_eop_n && widx != CW'(HW + 1)) wcnt_d = widx + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wcnt_q   <= '0;
            in_hdr_q <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            in_hdr_q <= in_hdr_d;
        end
    end
`else
    assign rx_data_mod = rx_data;
`endif

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && rx_eof_n) begin
                    state_d    = ST_LOCKED;
                    lock_idx_d = sel_idx;
                end
            end
            ST_LOCKED: begin
                if (accept && !rx_eof_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_vld_d  = tx_vld_q;
        tx_data_d = tx_data_q;
        tx_rem_d  = tx_rem_q;
        tx_dlm_d  = tx_dlm_q;
        if (accept) begin
            tx_vld_d  = 1'b1;
            tx_data_d = rx_data_mod;
            tx_rem_d  = rx_rem;
            tx_dlm_d  = {rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n};
        end else if (!TX_DST_RDY_N) begin
            tx_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
            tx_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_rem_q   <= '0;
            tx_dlm_q   <= 4'hF;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            tx_vld_q   <= tx_vld_d;
            tx_data_q  <= tx_data_d;
            tx_rem_q   <= tx_rem_d;
            tx_dlm_q   <= tx_dlm_d;
        end
    end

    assign TX_SRC_RDY_N = !tx_vld_q;
    assign TX_DATA      = tx_data_q;
    assign TX_REM       = tx_rem_q;
    assign TX_SOF_N     = tx_dlm_q[3];
    assign TX_EOF_N     = tx_dlm_q[2];
    assign TX_SOP_N     = tx_dlm_q[1];
    assign TX_EOP_N     = tx_dlm_q[0];

endmodule

// File: tb/tb_fl_ifnum_merge.sv
// Randomized and directed bench for fl_ifnum_merge against a frame-level round-robin model.
module tb_fl_ifnum_merge;

    localparam int DW   = 16;
    localparam int N    = 4;
    localparam int REMW = 1;
    localparam int IW   = 2;
    localparam int HW   = 10;
    localparam int HB   = 7;
`ifdef FL_IFNUM_MERGE_MARK_EN
    localparam bit MARK_EN = 1'b1;
`else
    localparam bit MARK_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic [N*DW-1:0]   RX_DATA;
    logic [N*REMW-1:0] RX_REM;
    logic [N-1:0]      RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N;
    logic [N-1:0]      RX_SRC_RDY_N, RX_DST_RDY_N;
    logic [DW-1:0]     TX_DATA;
    logic [REMW-1:0]   TX_REM;
    logic              TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N;
    logic              TX_SRC_RDY_N, TX_DST_RDY_N;

    always #5 CLK = ~CLK;

    fl_ifnum_merge #(
        .DATA_WIDTH   (DW),
        .IF_COUNT     (N),
        .IFNUM_OFFSET (167)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .RX_DATA      (RX_DATA),
        .RX_REM       (RX_REM),
        .RX_SOF_N     (RX_SOF_N),
        .RX_EOF_N     (RX_EOF_N),
        .RX_SOP_N     (RX_SOP_N),
        .RX_EOP_N     (RX_EOP_N),
        .RX_SRC_RDY_N (RX_SRC_RDY_N),
        .RX_DST_RDY_N (RX_DST_RDY_N),
        .TX_DATA      (TX_DATA),
        .TX_REM       (TX_REM),
        .TX_SOF_N     (TX_SOF_N),
        .TX_EOF_N     (TX_EOF_N),
        .TX_SOP_N     (TX_SOP_N),
        .TX_EOP_N     (TX_EOP_N),
        .TX_SRC_RDY_N (TX_SRC_RDY_N),
        .TX_DST_RDY_N (TX_DST_RDY_N)
    );

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [REMW-1:0] rem;
        logic            sof_n;
        logic            eof_n;
        logic            sop_n;
        logic            eop_n;
    } word_t;

    word_t src_q [N][$];
    word_t fr_q  [N][$];
    word_t exp_q [$];
    word_t out_q [$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add_frame(input int src, input int hdr_len, input int n_parts,
                             input bit fixed, input logic [DW-1:0] fill);
        word_t w;
        int    len;
        for (int p = 0; p <= n_parts; p++) begin
            len = (p == 0) ? hdr_len : int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                w.data  = fixed ? fill : DW'($urandom);
                w.rem   = REMW'($urandom);
                w.sof_n = !(p == 0 && j == 0);
                w.eof_n = !(p == n_parts && j == len - 1);
                w.sop_n = (j != 0);
                w.eop_n = (j != len - 1);
                src_q[src].push_back(w);
                fr_q[src].push_back(w);
            end
        end
    endtask

    // Whole frames leave in round-robin order over inputs that still hold frames.
    task automatic build_expected();
        int    ptr, f, k;
        bit    in_hdr, done;
        word_t w;
        ptr = 0;
        forever begin
            f = -1;
            for (int s = 0; s < N; s++)
                if (f < 0 && fr_q[(ptr + s) % N].size() > 0) f = (ptr + s) % N;
            if (f < 0) break;
            k = 0; in_hdr = 1'b1; done = 1'b0;
            while (!done && fr_q[f].size() > 0) begin
                w = fr_q[f].pop_front();
                if (MARK_EN && in_hdr && k == HW) w.data[HB +: IW] = IW'(f);
                exp_q.push_back(w);
                if (!w.eop_n) in_hdr = 1'b0;
                done = !w.eof_n;
                k++;
            end
            ptr = (f + 1) % N;
        end
    endtask

    task automatic drive_slot(input int i, input bit on);
        word_t w;
        w = on ? src_q[i][0] : word_t'('1);
        RX_DATA[i*DW +: DW]       = on ? w.data : '0;
        RX_REM[i*REMW +: REMW]    = on ? w.rem : '0;
        RX_SOF_N[i]               = w.sof_n;
        RX_EOF_N[i]               = w.eof_n;
        RX_SOP_N[i]               = w.sop_n;
        RX_EOP_N[i]               = w.eop_n;
        RX_SRC_RDY_N[i]           = !on;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) drive_slot(i, 1'b0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        TX_DST_RDY_N = 1'b0;
        RX_SRC_RDY_N = '0;
        RX_SOF_N = '0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            fr_q[i].delete();
        end
        exp_q.delete();
        @(negedge CLK);
        chk("rst_dst_rdy", RX_DST_RDY_N, 4'hF);
        @(posedge CLK); #1;
        chk("rst_tx", {TX_SRC_RDY_N, TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N},
            {1'b1, 16'h0, 1'b0, 4'hF});
        RESET_N = 1'b1;
        idle_inputs();
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run(input int gap_pct, input int stall_pct, input int stall_at,
                       input int max_cycles, output int bubbles);
        bit [N-1:0]  taken, pres;
        int          cyc;
        bit          started, prev_hold;
        logic [21:0] prev_tx, cur_tx;
        word_t       w;
        taken = '0; pres = '0; cyc = 0; started = 0; prev_hold = 0; prev_tx = '0;
        bubbles = 0;
        out_q.delete();
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            for (int i = 0; i < N; i++) begin
                if (taken[i]) begin
                    void'(src_q[i].pop_front());
                    pres[i] = 1'b0;
                end
                if (!pres[i] && src_q[i].size() > 0)
                    pres[i] = !src_q[i][0].sof_n || ($urandom_range(99) >= gap_pct);
                drive_slot(i, pres[i]);
            end
            TX_DST_RDY_N = (cyc >= stall_at && cyc < stall_at + 20) ||
                           ($urandom_range(99) < stall_pct);
            @(negedge CLK);
            taken  = ~RX_SRC_RDY_N & ~RX_DST_RDY_N;
            cur_tx = {TX_SRC_RDY_N, TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N};
            if (prev_hold) chk("tx_hold", cur_tx, prev_tx);
            prev_hold = !TX_SRC_RDY_N && TX_DST_RDY_N;
            prev_tx   = cur_tx;
            if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
                started = 1'b1;
                w = '{TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N};
                out_q.push_back(w);
                chk("tx_word", w, exp_q.pop_front());
            end else if (started && TX_SRC_RDY_N) begin
                bubbles++;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        chk("timeout_left", exp_q.size(), 0);
        for (int i = 0; i < N; i++)
            if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        idle_inputs();
        TX_DST_RDY_N = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("tx_extra", TX_SRC_RDY_N, 1'b1);
        end
        @(posedge CLK); #1;
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N; i++) n += src_q[i].size();
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, n;
        RESET_N = 1'b0;
        TX_DST_RDY_N = 1'b0;
        RX_DATA = '0; RX_REM = '0;
        RX_SOF_N = '1; RX_EOF_N = '1; RX_SOP_N = '1; RX_EOP_N = '1;
        RX_SRC_RDY_N = '1;

        // 12-word all-ones header on input 2.
        do_reset();
        add_frame(2, 12, 0, 1'b1, 16'hFFFF);
        build_expected();
        run(0, 0, -100, 200, b);
        chk("hdr10", out_q[10].data, MARK_EN ? 16'hFF7F : 16'hFFFF);
        chk("hdr9", out_q[9].data, 16'hFFFF);
        chk("len_hdr12", out_q.size(), 12);

        // All inputs present SOF together: order 0..3, no bubbles.
        do_reset();
        for (int i = 0; i < N; i++)
            add_frame(i, (i == 3) ? 12 : 3 + i, 1, 1'b1, DW'(16'h1111 * (i + 1)));
        n = pending();
        build_expected();
        run(0, 0, -100, 300, b);
        chk("bubbles", b, 0);
        chk("len_all4", out_q.size(), n);
        chk("first_src0", out_q[0].data, 16'h1111);

        // Short header on input 1 stays unmodified.
        do_reset();
        add_frame(1, 5, 2, 1'b0, '0);
        n = pending();
        build_expected();
        run(0, 0, -100, 200, b);
        chk("len_short", out_q.size(), n);

        // Long TX stall mid-frame.
        do_reset();
        add_frame(0, 12, 2, 1'b0, '0);
        n = pending();
        build_expected();
        run(0, 0, 5, 400, b);
        chk("len_stall", out_q.size(), n);

        // Header exactly HW+1 and HW words, back-to-back on one input.
        do_reset();
        add_frame(2, 11, 1, 1'b0, '0);
        add_frame(2, 10, 1, 1'b0, '0);
        build_expected();
        run(20, 20, -100, 400, b);

        // Reset mid-frame on input 0, then a frame on input 3.
        do_reset();
        add_frame(0, 12, 0, 1'b0, '0);
        fr_q[0].delete();
        TX_DST_RDY_N = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_slot(0, 1'b1);
            @(negedge CLK);
            chk("pre_rst_rdy", RX_DST_RDY_N[0], 1'b0);
            @(posedge CLK); #1;
            void'(src_q[0].pop_front());
        end
        drive_slot(0, 1'b1);
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("midrst_dst_rdy", RX_DST_RDY_N, 4'hF);
        @(posedge CLK); #1;
        chk("midrst_tx_idle", {TX_SRC_RDY_N, TX_DATA, TX_SOF_N}, {1'b1, 16'h0, 1'b1});
        RESET_N = 1'b1;
        add_frame(3, 12, 0, 1'b1, 16'h0000);
        build_expected();
        run(0, 0, -100, 200, b);
        chk("field3", out_q[10].data, MARK_EN ? 16'h0180 : 16'h0000);
        chk("len_after_rst", out_q.size(), 12);
        chk("err_held", src_q[0].size(), 8);

        // Randomized traffic with source gaps and TX back-pressure.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < N; i++)
                repeat ($urandom_range(0, 3))
                    add_frame(i, $urandom_range(1, 14), $urandom_range(0, 2), 1'b0, '0);
            n = pending();
            build_expected();
            run(30, 30, -100, 3000, b);
            chk("len_rand", out_q.size(), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fl_ifnum_merge.md
# fl_ifnum_merge

FrameLink N-to-1 merger: the return path of the FrameLink switch. Accepts frames on IF_COUNT FrameLink inputs, forwards whole frames (never interleaved) onto one FrameLink output under round-robin arbitration. Writes the source input number into the header at bit IFNUM_OFFSET, so a downstream switch configured with the same generics routes the frame back to its origin.

## Interface
- DATA_WIDTH, 16, FrameLink data width in bits (multiple of 8).
- IF_COUNT, 4, number of inputs (power of two, ≥2).
- IFNUM_OFFSET, 167, bit offset of the interface-number field within the first frame part (header).
- CLK  in  1  clock.
- RESET_N  in  1  synchronous, active-low reset.
- RX_DATA  in  IF_COUNT*DATA_WIDTH  input data; input i at slice i.
- RX_REM  in  IF_COUNT*log2(DATA_WIDTH/8)  input remainder.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  IF_COUNT  frame/part delimiters, active-low.
- RX_SRC_RDY_N  in  IF_COUNT  input valid, active-low.
- RX_DST_RDY_N  out  IF_COUNT  input ready, active-low.
- TX_DATA  out  DATA_WIDTH; TX_REM  out  log2(DATA_WIDTH/8).
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1  output delimiters.
- TX_SRC_RDY_N  out  1; TX_DST_RDY_N  in  1.

## Operation
- IFNUM_WIDTH = log2(IF_COUNT); field word HW = IFNUM_OFFSET / DATA_WIDTH, bit HB = IFNUM_OFFSET mod DATA_WIDTH; HB+IFNUM_WIDTH ≤ DATA_WIDTH is required (elaboration-time assertion).
- Output register (one word + delimiters + valid) loads when empty or when TX word is accepted (TX_SRC_RDY_N=0 and TX_DST_RDY_N=0) in the same cycle: "can_load".
- FSM IDLE: among inputs with RX_SRC_RDY_N=0 and RX_SOF_N=0, grant the first at or after pointer PTR (wrapping). If can_load, that word is accepted; go LOCKED (stay IDLE if word also has EOF_N=0).
- Input valid without SOF in IDLE: protocol error; held off (DST_RDY_N=1), not forwarded.
- LOCKED: only granted input sees RX_DST_RDY_N = not can_load; all others 1. Return to IDLE when EOF word accepted.
- On every accepted EOF word: PTR ← (granted+1) mod IF_COUNT.
- Header word counter: cleared on SOF accept, increments per accepted word until first EOP accepted, then frozen. Word with counter = HW, still in header part: bits HB+IFNUM_WIDTH-1..HB replaced with grant index. Header shorter than HW+1 words: frame passes unmodified.
- All other bits, REM and delimiters passed unchanged.

## Timing
- Reset (RESET_N=0 sampled at CLK edge): TX_SRC_RDY_N=1, TX_SOF_N/EOF_N/SOP_N/EOP_N=1, TX_DATA=0, TX_REM=0, output register empty, FSM IDLE, PTR=0, counter 0; RX_DST_RDY_N all 1 while RESET_N=0.
- Reset mid-frame: partial frame discarded from output immediately; the input's remainder is treated as protocol error (no SOF) until its next SOF.
- Latency: 1 cycle from RX accept to TX_SRC_RDY_N=0.
- Throughput: 1 word/cycle, including back-to-back frames from different inputs (EOF on one input and SOF grant on another in consecutive cycles, no bubble).
- RX_DST_RDY_N depends combinationally on TX_DST_RDY_N (no added cycle).
- TX outputs stable while TX_SRC_RDY_N=0 and TX_DST_RDY_N=1.

## Configuration
- FL_IFNUM_MERGE_MARK_EN defined: header field overwritten as above.
- Not defined: word counter and field rewrite removed; block is a pure frame-atomic round-robin multiplexer, data bit-exact.

## Structure
- Package fl_ifnum_merge_pkg: state enum (IDLE, LOCKED), functions for IFNUM_WIDTH, HW, HB from generics.
- Sub-module fl_ifnum_merge_arb: round-robin request/grant with PTR register and one-hot + binary grant outputs; FSM, counter, output register in top.

## Test plan
- Frame on input 2, header 12 words of 0xFFFF, MARK_EN on → TX header word 10 = 0xFF7F, all other words identical.
- Same frame, MARK_EN off → TX header word 10 = 0xFFFF.
- After reset, inputs 0..3 all present SOF in same cycle → frames emitted complete in order 0,1,2,3, no interleaving, no idle cycle between frames when TX_DST_RDY_N=0.
- Input 1 header of 5 words → frame forwarded unmodified.
- TX_DST_RDY_N held 1 for 20 cycles mid-frame → TX word held stable, no loss or duplication, total word count matches.
- RESET_N=0 one cycle mid-frame on input 0, then new frame on input 3 → TX idle cycle after reset, input 3 frame emitted intact with field = 3.
